soft_rst_req_gen: RTL and testbench



---
 rtl/soft_rst_req_gen.sv | 162 ++++++++++++++++
 tb/tb_soft_rst_req_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soft_rst_req_gen.sv
// Soft-reset request generator: keyed APB requests and a watchdog drive
// cpu_pad_soft_rst into the MCU reset controller. Resets on POR only.
module soft_rst_req_gen #(
  parameter int PULSE_CYCLES   = 4,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int WDT_WIDTH      = 24
) (
  input  logic        sys_clk,
  input  logic        mcu_rst_signal,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [1:0]  cpu_pad_soft_rst,
  output logic        rst_busy
);

  localparam int CMAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ?
                        PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           cause;
  logic [WDT_WIDTH-1:0] wdt_load;
  logic [WDT_WIDTH-1:0] wdt_cnt;
  logic                 wdt_en;

  logic       acc;
  logic       wr;
  logic [1:0] sel;
  logic       wr_ctrl;
  logic       wr_cause;
  logic       wr_load;
  logic       wr_wctl;
  logic       key_ok;
  logic       is_idle;
  logic       ctrl_err;
  logic       sw_ok;
  logic       sw_core;
  logic       sw_sys;
  logic       wdt_fire;
  logic       sys_req;
  logic       req;
  logic       kick;
  logic       en_rise;
  logic [3:0] cause_set;
  logic [3:0] cause_clr;
  logic       unused_bits;

  assign acc      = psel & penable;
  assign wr       = acc & pwrite;
  assign sel      = paddr[3:2];
  assign wr_ctrl  = wr && (sel == 2'd0);
  assign wr_cause = wr && (sel == 2'd1);
  assign wr_load  = wr && (sel == 2'd2);
  assign wr_wctl  = wr && (sel == 2'd3);
  assign key_ok   = (pwdata[15:8] == 8'h5A);
  assign is_idle  = (state == IDLE);

  // Request bits while busy are refused; a keyed no-op is always fine
  assign ctrl_err = wr_ctrl &&
                    (!key_ok || ((pwdata[1:0] != 2'b00) && !is_idle));
  assign sw_ok    = wr_ctrl && !ctrl_err;
  assign sw_core  = sw_ok && pwdata[0];
  assign sw_sys   = sw_ok && pwdata[1];
  assign wdt_fire = wdt_en && is_idle && (wdt_cnt == '0);
  assign sys_req  = sw_sys | wdt_fire;
  assign req      = sys_req | sw_core;
  assign kick     = wr_wctl && (pwdata[15:8] == 8'hA5);
  assign en_rise  = wr_wctl && !kick && pwdata[0] && !wdt_en;

  assign cause_set = {wdt_fire, sw_sys, sw_core & ~sys_req, 1'b0};
  assign cause_clr = wr_cause ? pwdata[3:0] : 4'd0;

  assign pready      = 1'b1;
  assign pslverr     = ctrl_err;
  assign unused_bits = ^{paddr[1:0], pwdata[31:16]};

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (sel)
        2'd1:    prdata = {28'd0, cause};
        2'd2:    prdata = 32'(wdt_load);
        2'd3:    prdata = {31'd0, wdt_en};
        default: prdata = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      state            <= IDLE;
      cnt              <= '0;
      cause            <= 4'b0001;
      wdt_load         <= '1;
      wdt_cnt          <= '1;
      wdt_en           <= 1'b0;
      cpu_pad_soft_rst <= 2'b00;
      rst_busy         <= 1'b0;
    end else begin
      cause <= (cause & ~cause_clr) | cause_set;

      if (wr_load) wdt_load <= pwdata[WDT_WIDTH-1:0];

      if (kick || en_rise)
        wdt_cnt <= wdt_load;
      else if (wdt_en && is_idle && (wdt_cnt != '0))
        wdt_cnt <= wdt_cnt - 1'b1;

      if (req)
        wdt_en <= 1'b0;
      else if (wr_wctl && !kick)
        wdt_en <= pwdata[0];

      unique case (state)
        IDLE: begin
          if (req) begin
            state            <= ASSERT;
            cnt              <= CW'(PULSE_CYCLES - 1);
            cpu_pad_soft_rst <= sys_req ? 2'b10 : 2'b01;
            rst_busy         <= 1'b1;
          end
        end
        ASSERT: begin
          if (cnt == '0) begin
            state            <= HOLDOFF;
            cnt              <= CW'(HOLDOFF_CYCLES - 1);
            cpu_pad_soft_rst <= 2'b00;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLDOFF: begin
          if (cnt == '0) begin
            state    <= IDLE;
            rst_busy <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state            <= IDLE;
          cpu_pad_soft_rst <= 2'b00;
          rst_busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soft_rst_req_gen.sv
// Scoreboard bench for soft_rst_req_gen: event-time reference model,
// APB and pulse monitors decoupled from the random/directed driver.
module tb_soft_rst_req_gen;

  localparam int P = 4;
  localparam int H = 16;

  logic        sys_clk = 1'b0;
  logic        mcu_rst_signal = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [3:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [1:0]  cpu_pad_soft_rst;
  logic        rst_busy;

  soft_rst_req_gen #(
    .PULSE_CYCLES  (P),
    .HOLDOFF_CYCLES(H),
    .WDT_WIDTH     (24)
  ) dut (
    .sys_clk         (sys_clk),
    .mcu_rst_signal  (mcu_rst_signal),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .paddr           (paddr),
    .pwdata          (pwdata),
    .prdata          (prdata),
    .pready          (pready),
    .pslverr         (pslverr),
    .cpu_pad_soft_rst(cpu_pad_soft_rst),
    .rst_busy        (rst_busy)
  );

  always #5 sys_clk = ~sys_clk;

  longint cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void check(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
  } acc_t;

  typedef struct {
    logic [1:0] bits;
    longint     start;
  } pul_t;

  acc_t acc_q[$];
  pul_t pul_q[$];

  // Reference model: times are absolute cycle numbers
  logic [3:0]  m_cause;
  bit          m_en;
  logic [23:0] m_load;
  longint      m_f;
  longint      m_idle;

  function automatic void m_reset();
    m_cause = 4'b0001;
    m_en    = 1'b0;
    m_load  = '1;
    m_f     = 0;
    m_idle  = 0;
    pul_q.delete();
  endfunction

  function automatic longint deadline(longint c);
    longint s;
    s = (c + 1 > m_idle) ? c + 1 : m_idle;
    return s + longint'(m_load);
  endfunction

  function automatic void m_start(longint c, logic [1:0] bits,
                                  logic [3:0] set);
    pul_t p;
    p.bits = bits;
    p.start = c + 1;
    pul_q.push_back(p);
    m_cause = m_cause | set;
    m_en    = 1'b0;
    m_idle  = c + 1 + P + H;
  endfunction

  function automatic void advance(longint t);
    if (m_en && m_f <= t) m_start(m_f, 2'b10, 4'b1000);
  endfunction

  function automatic void m_access(longint c, bit wr, logic [1:0] a,
                                   logic [31:0] d);
    acc_t e;
    bit fire, busy, sw0, sw1;
    fire = m_en && (m_f == c);
    busy = (c < m_idle);
    e.rd = !wr;
    e.data = '0;
    e.err = 1'b0;
    sw0 = 1'b0;
    sw1 = 1'b0;
    if (!wr) begin
      case (a)
        2'd1:    e.data = {28'd0, m_cause};
        2'd2:    e.data = {8'd0, m_load};
        2'd3:    e.data = {31'd0, m_en};
        default: e.data = '0;
      endcase
    end else begin
      case (a)
        2'd0: begin
          if (d[15:8] != 8'h5A || (d[1:0] != 2'b00 && busy)) e.err = 1'b1;
          else begin
            sw0 = d[0];
            sw1 = d[1];
          end
        end
        2'd1: m_cause = m_cause & ~d[3:0];
        2'd2: m_load = d[23:0];
        default: begin
          if (d[15:8] == 8'hA5) begin
            if (m_en) m_f = deadline(c);
          end else begin
            if (d[0] && !m_en) m_f = deadline(c);
            m_en = d[0];
          end
        end
      endcase
    end
    if (fire || sw1) m_start(c, 2'b10, {fire, sw1, 2'b00});
    else if (sw0) m_start(c, 2'b01, 4'b0010);
    acc_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
    advance(cyc);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic apb(bit wr, logic [1:0] a, logic [31:0] d);
    tick();
    psel = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = {a, 2'b00};
    pwdata = d;
    m_access(cyc + 1, wr, a, d);
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0;
    penable = 1'b0;
    pwrite = 1'b0;
  endtask

  // Monitors
  bit         in_p = 0;
  bit         in_b = 0;
  int         pw = 0;
  int         bw = 0;
  logic [1:0] p_bits = 0;

  always @(negedge sys_clk) begin
    acc_t e;
    pul_t p;
    if (psel && penable && mcu_rst_signal) begin
      if (acc_q.size() == 0) begin
        check("apb_unexpected_access", 1, 0);
      end else begin
        e = acc_q.pop_front();
        check("pslverr", pslverr, e.err);
        check("pready", pready, 1);
        if (e.rd) check("prdata", prdata, e.data);
      end
    end
    if (!mcu_rst_signal) begin
      in_p = 0;
      in_b = 0;
    end else begin
      if (cpu_pad_soft_rst != 2'b00) begin
        if (!in_p) begin
          in_p = 1;
          pw = 1;
          p_bits = cpu_pad_soft_rst;
          if (pul_q.size() == 0) begin
            check("unexpected_pulse", cpu_pad_soft_rst, 0);
          end else begin
            p = pul_q.pop_front();
            check("pulse_bits", cpu_pad_soft_rst, p.bits);
            check("pulse_start", cyc, p.start);
          end
        end else begin
          pw++;
          check("pulse_stable", cpu_pad_soft_rst, p_bits);
        end
      end else if (in_p) begin
        in_p = 0;
        check("pulse_width", pw, P);
      end
      if (rst_busy) begin
        if (!in_b) begin
          in_b = 1;
          bw = 1;
        end else bw++;
      end else if (in_b) begin
        in_b = 0;
        check("busy_width", bw, P + H);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [7:0] key;
    m_reset();
    idle(3);
    @(negedge sys_clk);
    check("rst_pad", cpu_pad_soft_rst, 0);
    check("rst_busy", rst_busy, 0);
    check("rst_pslverr", pslverr, 0);
    check("rst_prdata", prdata, 0);
    mcu_rst_signal = 1'b1;
    m_reset();

    apb(0, 2'd1, 0);
    apb(1, 2'd1, 32'h1);
    apb(0, 2'd1, 0);
    apb(0, 2'd0, 0);

    apb(1, 2'd0, 32'h5A01);
    idle(25);
    apb(0, 2'd1, 0);

    apb(1, 2'd0, 32'h3303);
    idle(3);
    apb(1, 2'd1, 32'hF);
    apb(1, 2'd0, 32'h5A03);
    idle(25);
    apb(0, 2'd1, 0);
    apb(1, 2'd1, 32'hF);

    apb(1, 2'd2, 32'd10);
    apb(0, 2'd2, 0);
    apb(1, 2'd3, 32'h1);
    idle(35);
    apb(0, 2'd3, 0);
    apb(0, 2'd1, 0);

    apb(1, 2'd3, 32'h1);
    for (int i = 0; i < 13; i++) begin
      idle(5);
      apb(1, 2'd3, 32'hA500);
    end
    apb(0, 2'd3, 0);
    idle(35);
    apb(0, 2'd1, 0);

    apb(1, 2'd0, 32'h5A01);
    idle(6);
    apb(1, 2'd0, 32'h5A01);
    apb(1, 2'd0, 32'h5A00);
    idle(25);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        apb(0, 2'($urandom_range(0, 3)), 0);
      end else if (r <= 3) begin
        key = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h5A;
        apb(1, 2'd0, {16'($urandom), key, 6'($urandom),
                      2'($urandom_range(0, 3))});
      end else if (r == 4) begin
        apb(1, 2'd1, $urandom);
      end else if (r == 5) begin
        apb(1, 2'd2, {8'($urandom), 24'($urandom_range(0, 40))});
      end else if (r <= 7) begin
        if ($urandom_range(0, 1) == 1)
          apb(1, 2'd3, {16'($urandom), 8'hA5, 8'($urandom)});
        else
          apb(1, 2'd3, {16'($urandom), 8'h00, 7'($urandom),
                        1'($urandom)});
      end else begin
        idle($urandom_range(0, 25));
      end
    end

    apb(1, 2'd3, 32'h0);
    idle(30);
    apb(1, 2'd0, 32'h5A01);
    idle(1);
    #1;
    mcu_rst_signal = 1'b0;
    #1;
    check("async_pad", cpu_pad_soft_rst, 0);
    check("async_busy", rst_busy, 0);
    m_reset();
    idle(2);
    @(negedge sys_clk);
    mcu_rst_signal = 1'b1;
    apb(0, 2'd1, 0);
    apb(0, 2'd3, 0);
    apb(0, 2'd2, 0);
    idle(30);

    check("pulse_queue_empty", pul_q.size(), 0);
    check("access_queue_empty", acc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
